// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared types and default sizing for the multi-port register file.
// Optional feature macro used by reg_file_mp: REG_FILE_MP_BYPASS_EN.
package reg_file_mp_pkg;

  typedef enum logic {CLEAR, READY} rf_state_e;

  localparam int RF_ADW = 5;
  localparam int RF_DPW = 32;
  localparam int RF_NRP = 2;
  localparam int RF_NWP = 1;

endpackage

// File: rtl/reg_file_mp_write_arb.sv
// rf_write_arb: resolves the write ports into one enable and one data word per
// entry. When several ports hit the same entry, the highest port index wins.
// The zero register, when enabled, never receives a write.
module rf_write_arb
  import reg_file_mp_pkg::*;
#(
  parameter int ADW      = RF_ADW,
  parameter int DPW      = RF_DPW,
  parameter int NWP      = RF_NWP,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 2**ADW
) (
  input  logic [NWP-1:0][ADW-1:0]   addr_w_i,
  input  logic [NWP-1:0]            we_i,
  input  logic [NWP-1:0][DPW-1:0]   wd_i,
  output logic [DEPTH-1:0]          ent_we_o,
  output logic [DEPTH-1:0][DPW-1:0] ent_wd_o
);

  // Per-entry decode; ascending port order lets higher ports overwrite lower ones.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ent_we_o = '0;
    ent_wd_o = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = 0; p < NWP; p++) begin
        if (we_i[p] && (addr_w_i[p] == ADW'(e))) begin
          ent_we_o[e] = 1'b1;
          ent_wd_o[e] = wd_i[p];
        end
      end
    end
    if (ZERO_REG != 0) begin
      ent_we_o[0] = 1'b0;
      ent_wd_o[0] = '0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: NRP asynchronous read ports, NWP synchronous write ports,
// optional hardwired-zero entry 0, and a DEPTH-cycle clear sweep after reset.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to the reads.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int ADW      = RF_ADW,
  parameter int DPW      = RF_DPW,
  parameter int NRP      = RF_NRP,
  parameter int NWP      = RF_NWP,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRP-1:0][ADW-1:0] addr_r,
  output logic [NRP-1:0][DPW-1:0] rd,
  input  logic [NWP-1:0][ADW-1:0] addr_w,
  input  logic [NWP-1:0]          we,
  input  logic [NWP-1:0][DPW-1:0] wd,
  output logic                    init_done
);

  localparam int DEPTH = 2**ADW;
  localparam logic [ADW-1:0] LAST_PTR = '1;

  rf_state_e        state_q;
  logic [ADW-1:0]   clr_ptr_q;
  logic             init_done_q;
  logic [DPW-1:0]   mem_q [DEPTH];

  logic [DEPTH-1:0]          ent_we;
  logic [DEPTH-1:0][DPW-1:0] ent_wd;

  rf_write_arb #(
    .ADW      (ADW),
    .DPW      (DPW),
    .NWP      (NWP),
    .ZERO_REG (ZERO_REG),
    .DEPTH    (DEPTH)
  ) u_write_arb (
    .addr_w_i (addr_w),
    .we_i     (we),
    .wd_i     (wd),
    .ent_we_o (ent_we),
    .ent_wd_o (ent_wd)
  );

  // Sweep control: walk clr_ptr over every entry, then hold READY until reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_ptr_q == LAST_PTR) begin
            state_q     <= READY;
            init_done_q <= 1'b1;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        READY:   state_q <= READY;
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Storage: zeroed one entry per cycle by the sweep, then written by the arbiter.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; clearing it is the sweep's job, which keeps it RAM-friendly.
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (state_q == READY) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (ent_we[e]) mem_q[e] <= ent_wd[e];
        end
      end
    end
  end

  // Read muxes: stored value, optional forwarding, then zero forcing.
  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      rd[i] = mem_q[addr_r[i]];
`ifdef REG_FILE_MP_BYPASS_EN
      if ((state_q == READY) && ent_we[addr_r[i]]) rd[i] = ent_wd[addr_r[i]];
`endif
      if ((state_q != READY) || ((ZERO_REG != 0) && (addr_r[i] == '0))) rd[i] = '0;
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (ADW=5, DPW=32, NRP=2, NWP=2, ZERO_REG=1).
module tb_reg_file_mp;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][4:0]  addr_r;
  logic [1:0][31:0] rd;
  logic [1:0][4:0]  addr_w;
  logic [1:0]       we;
  logic [1:0][31:0] wd;
  logic             init_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_mp #(
    .ADW(5), .DPW(32), .NRP(2), .NWP(2), .ZERO_REG(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_r    (addr_r),
    .rd        (rd),
    .addr_w    (addr_w),
    .we        (we),
    .wd        (wd),
    .init_done (init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = '0; addr_w = '0; wd = '0; addr_r = '0;

    // 1. Clear sweep: rst for 3 cycles, then init_done low for exactly 32 cycles.
    step(); step(); step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr_r[0] = 5'(i);
      addr_r[1] = 5'(31 - i);
      #1;
      check("sweep_init_done_low", {31'b0, init_done}, 32'h0);
      check("sweep_rd0_zero", rd[0], 32'h0);
      check("sweep_rd1_zero", rd[1], 32'h0);
      step();
    end
    check("sweep_init_done_high", {31'b0, init_done}, 32'h1);
    for (int i = 0; i < 32; i++) begin
      addr_r[0] = 5'(i);
      #1;
      check("post_sweep_zero", rd[0], 32'h0);
    end

    // 2. Basic write/read on port 0, both read ports on the same address.
    addr_w[0] = 5'd7; wd[0] = 32'hDEADBEEF; we = 2'b01;
    addr_r[0] = 5'd7; addr_r[1] = 5'd7;
    step();
    we = '0;
    #1;
    check("basic_rd0", rd[0], 32'hDEADBEEF);
    check("basic_rd1", rd[1], 32'hDEADBEEF);

    // 3. Collision at addr 12: port 1 wins.
    addr_w[0] = 5'd12; wd[0] = 32'h1111_1111;
    addr_w[1] = 5'd12; wd[1] = 32'h2222_2222;
    we = 2'b11;
    step();
    we = '0;
    addr_r[0] = 5'd12; addr_r[1] = 5'd7;
    #1;
    check("collision_hi_wins", rd[0], 32'h2222_2222);
    check("collision_other_kept", rd[1], 32'hDEADBEEF);

    // 3b. Two ports on different addresses both land.
    addr_w[0] = 5'd13; wd[0] = 32'h0000_1313;
    addr_w[1] = 5'd14; wd[1] = 32'h0000_1414;
    we = 2'b11;
    step();
    we = '0;
    addr_r[0] = 5'd13; addr_r[1] = 5'd14;
    #1;
    check("dual_write_p0", rd[0], 32'h0000_1313);
    check("dual_write_p1", rd[1], 32'h0000_1414);

    // 4. Zero register ignores writes, also in the write cycle.
    addr_w[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; we = 2'b01;
    addr_r[0] = 5'd0;
    #1;
    check("zero_reg_write_cycle", rd[0], 32'h0);
    step();
    we = '0;
    #1;
    check("zero_reg_after", rd[0], 32'h0);

    // 5. Same-cycle write/read of addr 3.
    addr_w[0] = 5'd3; wd[0] = 32'h0000_0033; we = 2'b01;
    step();
    addr_w[0] = 5'd3; wd[0] = 32'hA5A5_0001; we = 2'b01;
    addr_r[0] = 5'd3;
    #1;
`ifdef REG_FILE_MP_BYPASS_EN
    check("bypass_same_cycle", rd[0], 32'hA5A5_0001);
`else
    check("no_bypass_same_cycle", rd[0], 32'h0000_0033);
`endif
    step();
    we = '0;
    #1;
    check("bypass_next_cycle", rd[0], 32'hA5A5_0001);

    // 6. Reset mid-operation with a write pending; writes during the sweep are ignored.
    addr_w[0] = 5'd5; wd[0] = 32'h0000_0055; we = 2'b01;
    step();
    we = '0;
    addr_r[0] = 5'd5;
    #1;
    check("fill_addr5", rd[0], 32'h0000_0055);
    rst = 1'b1;
    addr_w[0] = 5'd9; wd[0] = 32'h0000_0099; we = 2'b01;
    step();
    rst = 1'b0;
    addr_w[0] = 5'd20; wd[0] = 32'h0000_0BAD; we = 2'b01;
    addr_r[1] = 5'd20;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("resweep_init_done_low", {31'b0, init_done}, 32'h0);
      check("resweep_rd_forced_zero", rd[0], 32'h0);
      step();
    end
    we = '0;
    #1;
    check("resweep_init_done_high", {31'b0, init_done}, 32'h1);
    check("resweep_addr5_cleared", rd[0], 32'h0);
    check("sweep_write_ignored", rd[1], 32'h0);
    addr_r[0] = 5'd9; addr_r[1] = 5'd7;
    #1;
    check("reset_write_dropped", rd[0], 32'h0);
    check("resweep_addr7_cleared", rd[1], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
